// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz VGA timing constants and counter helpers.
// The figure generator reuses these constants for its screen limits.
package vga_timing_pkg;

    localparam int CLK_DIV  = 4;
    localparam int H_VIS    = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_VIS    = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VIS + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_VIS + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    localparam int COORD_W  = 10;
    typedef logic [COORD_W-1:0] coord_t;

    function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Anything at or beyond the last count, including unreachable values, restarts at zero.
    function automatic coord_t next_count(input coord_t c, input coord_t last);
        if (c >= last) begin
            return {COORD_W{1'b0}};
        end else begin
            return c + coord_t'(1);
        end
    endfunction

endpackage

// File: rtl/divisor_pixel.sv
// Mod-CLK_DIV counter producing a one-clock pixel-rate enable.
module divisor_pixel #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_p_tick
);

    localparam int            DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] r_div;

    // Free-running divider, restarts at zero after the last phase.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div <= {DW{1'b0}};
        end else if (r_div >= LAST) begin
            r_div <= {DW{1'b0}};
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    assign o_p_tick = (r_div == LAST);

endmodule

// File: rtl/sincronizacion_vga.sv
// VGA timing generator: pixel/line counters, visible flag and registered syncs
// that change on the same edge as the coordinates they describe.
module sincronizacion_vga
    import vga_timing_pkg::coord_t;
    import vga_timing_pkg::in_window;
    import vga_timing_pkg::next_count;
#(
    parameter int CLK_DIV = vga_timing_pkg::CLK_DIV,
    parameter int H_VIS   = vga_timing_pkg::H_VIS,
    parameter int H_FP    = vga_timing_pkg::H_FP,
    parameter int H_SYNC  = vga_timing_pkg::H_SYNC,
    parameter int H_BP    = vga_timing_pkg::H_BP,
    parameter int V_VIS   = vga_timing_pkg::V_VIS,
    parameter int V_FP    = vga_timing_pkg::V_FP,
    parameter int V_SYNC  = vga_timing_pkg::V_SYNC,
    parameter int V_BP    = vga_timing_pkg::V_BP
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       frame_start
);

    localparam coord_t H_LAST   = coord_t'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam coord_t V_LAST   = coord_t'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam coord_t H_VIS_C  = coord_t'(H_VIS);
    localparam coord_t V_VIS_C  = coord_t'(V_VIS);
    localparam coord_t HS_START = coord_t'(H_VIS + H_FP);
    localparam coord_t HS_END   = coord_t'(H_VIS + H_FP + H_SYNC - 1);
    localparam coord_t VS_START = coord_t'(V_VIS + V_FP);
    localparam coord_t VS_END   = coord_t'(V_VIS + V_FP + V_SYNC - 1);

    logic   w_p_tick;
    logic   w_wrap;
    coord_t w_h_next;
    coord_t w_v_next;
    coord_t r_h;
    coord_t r_v;
    logic   r_hsync;
    logic   r_vsync;
    logic   r_frame_start;

    divisor_pixel #(
        .CLK_DIV (CLK_DIV)
    ) u_divisor_pixel (
        .i_clk    (clk),
        .i_rst_n  (reset),
        .o_p_tick (w_p_tick)
    );

    // Next counter values; an out-of-range line count also resyncs on the next tick.
    always_comb begin
        w_h_next = r_h;
        w_v_next = r_v;
        if (w_p_tick) begin
            w_h_next = next_count(r_h, H_LAST);
            if ((r_h == H_LAST) || (r_v > V_LAST)) begin
                w_v_next = next_count(r_v, V_LAST);
            end else begin
                w_v_next = r_v;
            end
        end else begin
            w_h_next = r_h;
            w_v_next = r_v;
        end
    end

    assign w_wrap = w_p_tick && (r_h == H_LAST) && (r_v == V_LAST);

    // Counters and syncs share one load so sync edges line up with the coordinates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_h           <= 10'd0;
            r_v           <= 10'd0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_wrap;
            if (w_p_tick) begin
                r_h     <= w_h_next;
                r_v     <= w_v_next;
                r_hsync <= ~in_window(w_h_next, HS_START, HS_END);
                r_vsync <= ~in_window(w_v_next, VS_START, VS_END);
            end
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign p_tick      = w_p_tick;
    assign pixel_x     = r_h;
    assign pixel_y     = r_v;
    assign frame_start = r_frame_start;
    assign video_on    = (r_h < H_VIS_C) && (r_v < V_VIS_C);

endmodule

// File: doc/sincronizacion_vga.md
Name: sincronizacion_vga

Overview:
Generates 640x480@60 Hz VGA timing from the 100 MHz system clock. It drives the pixel coordinates and the visible-region flag consumed by the figure/box generator and the text overlays. It also drives the hsync/vsync pins to the monitor. It is the first stage of the video path: counters feed the pixel-generation stages, and the sync outputs go directly to the connector.

Parameters:
CLK_DIV, 4, system clocks per pixel (100 MHz / 4 = 25 MHz pixel rate)
H_VIS, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels); H_TOTAL = 800
V_VIS, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync pulse width (lines)
V_BP, 33, vertical back porch (lines); V_TOTAL = 525

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-low reset
hsync  out  1  horizontal sync to monitor, active low, registered
vsync  out  1  vertical sync to monitor, active low, registered
video_on  out  1  high when pixel_x<H_VIS and pixel_y<V_VIS
p_tick  out  1  one-clk pixel-rate enable, high every CLK_DIV clocks
pixel_x  out  10  current horizontal count, 0..H_TOTAL-1
pixel_y  out  10  current vertical count, 0..V_TOTAL-1
frame_start  out  1  one-clk pulse when counters go from (799,524) to (0,0)

Behaviour:
- Reset (reset=0, asynchronous): div counter=0, h_count=0, v_count=0, hsync=1, vsync=1, frame_start=0.
  - Resulting outputs: p_tick=0, pixel_x=0, pixel_y=0, video_on=1 (decoded from 0,0).
- Divider: a mod-CLK_DIV counter; p_tick=1 while div==CLK_DIV-1.
  - First p_tick after reset release occurs in the 4th clock.
  - All h/v updates happen only on the clock edge where p_tick=1.
- Horizontal counter: h_count increments 0..799 on each p_tick; 799 wraps to 0.
- Vertical counter: v_count increments only on the p_tick where h_count==799; 524 wraps to 0.
  - Both counters wrap on the same edge at (799,524).
- pixel_x/pixel_y are the counter registers directly, with no added latency. video_on is a combinational decode of the registered counters.
- hsync and vsync are registered. On each p_tick edge they are loaded from the next-state counter values, so they are aligned with pixel_x/pixel_y (zero relative skew) and glitch-free.
  - hsync=0 iff next h in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] = [656,751]; otherwise 1.
  - vsync=0 iff next v in [490,491]; otherwise 1.
- frame_start: registered. Set to 1 for exactly one clk on the edge where the counters wrap to (0,0); 0 otherwise.
- Width rules:
  - Counters are 10 bits.
  - Out-of-range values are unreachable, but any h_count>799 or v_count>524 must wrap to 0 on the next p_tick.
  - Comparisons are unsigned.
- Frame period = 800*525*4 = 1,680,000 clk; line period = 3200 clk.
- Reset mid-frame: immediate return to reset values. Timing restarts from (0,0) with no partial sync pulse held low.
- No input handshake: free-running. Downstream samples coordinates on any clock; values are stable for CLK_DIV clocks.

Decomposition:
- Shared package vga_timing_pkg holds:
  - H_VIS, H_FP, H_SYNC, H_BP, V_VIS, V_FP, V_SYNC, V_BP
  - derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END
  - These are reused by the figure generator for screen limits (MAX_X/MAX_Y).
- One sub-module: divisor_pixel (mod-CLK_DIV counter emitting p_tick). H/V counters and sync registers stay in sincronizacion_vga.

Test Plan:
- Reset check: assert reset=0 for 5 clk -> pixel_x=0, pixel_y=0, hsync=1, vsync=1, p_tick=0, frame_start=0. Release -> first p_tick at clock 4, pixel_x=1 after that edge.
- Line wrap: run to pixel_x=799, pixel_y=10, next p_tick -> pixel_x=0, pixel_y=11. Line period measured = 3200 clk.
- hsync window: hsync falls on the same edge pixel_x becomes 656, rises on the edge pixel_x becomes 752. Low for exactly 96 p_ticks (384 clk). video_on=0 for pixel_x>=640.
- vsync/frame: vsync low exactly while pixel_y in {490,491} (6400 clk). frame_start pulses once per 1,680,000 clk, coincident with (0,0). Count of video_on=1 p_ticks per frame = 307,200.
- Reset mid-frame: at pixel_x=700, pixel_y=491 (hsync=0, vsync=0), pulse reset=0 for 1 clk -> hsync=1, vsync=1, counters=0 asynchronously. Timing restarts cleanly.
- Alignment: over 2 frames, assert hsync==!(656<=pixel_x<=751) and vsync==!(490<=pixel_y<=491) on every clk.
